rotation_kick_sequencer: RTL and testbench

Sequences SRS wall-kick attempts for a single rotation request from the game FSM. Walks kick steps 0..4 on the clockwise or counter-clockwise kick table, and forms each candidate position. Submits each candidate to the shared board collision checker through a valid/response handshake. Commits the first collision-free placement or reports failure. Sits between the game control FSM, the two wall-kick lookup tables and the collision checker.

---
 rtl/rotation_kick_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_rotation_kick_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_kick_sequencer.sv
// rotation_kick_sequencer: walks SRS wall-kick steps for one rotation request,
// forms each candidate placement from the kick tables and commits the first
// placement the shared collision checker reports as free.

package rotation_kick_pkg;
    typedef logic [2:0] tetromino_idx_t;
    localparam tetromino_idx_t TET_I = 3'd0;
    localparam tetromino_idx_t TET_O = 3'd1;
    localparam tetromino_idx_t TET_T = 3'd2;
    localparam tetromino_idx_t TET_S = 3'd3;
    localparam tetromino_idx_t TET_Z = 3'd4;
    localparam tetromino_idx_t TET_J = 3'd5;
    localparam tetromino_idx_t TET_L = 3'd6;
endpackage

module rotation_kick_sequencer
    import rotation_kick_pkg::*;
#(
    parameter int X_WIDTH = 5,
    parameter int Y_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rot_req,
    input  logic                      rot_dir,
    input  logic                      abort,
    input  logic signed [X_WIDTH-1:0] cur_x,
    input  logic signed [Y_WIDTH-1:0] cur_y,
    input  logic        [1:0]         cur_rotation,
    input  tetromino_idx_t            idx,
    output logic        [1:0]         kick_rotation,
    output logic        [2:0]         kick_step,
    output tetromino_idx_t            kick_idx,
    input  logic signed [2:0]         cw_add_x,
    input  logic signed [2:0]         cw_add_y,
    input  logic signed [2:0]         ccw_add_x,
    input  logic signed [2:0]         ccw_add_y,
    output logic                      chk_valid,
    output logic signed [X_WIDTH-1:0] chk_x,
    output logic signed [Y_WIDTH-1:0] chk_y,
    output logic        [1:0]         chk_rotation,
    input  logic                      chk_resp,
    input  logic                      chk_collide,
    output logic                      busy,
    output logic                      done,
    output logic                      success,
    output logic signed [X_WIDTH-1:0] new_x,
    output logic signed [Y_WIDTH-1:0] new_y,
    output logic        [1:0]         new_rotation
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CHECK, S_DONE} state_t;

    localparam logic [2:0] LAST_STEP = 3'd4;

    state_t                      state_q, state_d;
    logic        [2:0]           step_q, step_d;
    logic signed [X_WIDTH-1:0]   lx_q, lx_d;
    logic signed [Y_WIDTH-1:0]   ly_q, ly_d;
    logic        [1:0]           lrot_q, lrot_d;
    logic        [1:0]           trot_q, trot_d;
    tetromino_idx_t              lidx_q, lidx_d;
    logic                        ldir_q, ldir_d;
    logic signed [X_WIDTH-1:0]   chk_x_q, chk_x_d;
    logic signed [Y_WIDTH-1:0]   chk_y_q, chk_y_d;
    logic        [1:0]           chk_rot_q, chk_rot_d;
    logic signed [X_WIDTH-1:0]   new_x_q, new_x_d;
    logic signed [Y_WIDTH-1:0]   new_y_q, new_y_d;
    logic        [1:0]           new_rot_q, new_rot_d;
    logic                        success_q, success_d;
    logic signed [2:0]           add_x, add_y;

    // Kick offsets are 3-bit signed; widen them to the coordinate widths.
    function automatic logic signed [X_WIDTH-1:0] sext_x(input logic signed [2:0] a);
        return {{(X_WIDTH-3){a[2]}}, a};
    endfunction

    function automatic logic signed [Y_WIDTH-1:0] sext_y(input logic signed [2:0] a);
        return {{(Y_WIDTH-3){a[2]}}, a};
    endfunction

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            lx_q      <= '0;
            ly_q      <= '0;
            lrot_q    <= '0;
            trot_q    <= '0;
            lidx_q    <= '0;
            ldir_q    <= 1'b0;
            chk_x_q   <= '0;
            chk_y_q   <= '0;
            chk_rot_q <= '0;
            new_x_q   <= '0;
            new_y_q   <= '0;
            new_rot_q <= '0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            lrot_q    <= lrot_d;
            trot_q    <= trot_d;
            lidx_q    <= lidx_d;
            ldir_q    <= ldir_d;
            chk_x_q   <= chk_x_d;
            chk_y_q   <= chk_y_d;
            chk_rot_q <= chk_rot_d;
            new_x_q   <= new_x_d;
            new_y_q   <= new_y_d;
            new_rot_q <= new_rot_d;
            success_q <= success_d;
        end
    end

    // Next-state logic: accept, form candidate, await checker, finish.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        lrot_d    = lrot_q;
        trot_d    = trot_q;
        lidx_d    = lidx_q;
        ldir_d    = ldir_q;
        chk_x_d   = chk_x_q;
        chk_y_d   = chk_y_q;
        chk_rot_d = chk_rot_q;
        new_x_d   = new_x_q;
        new_y_d   = new_y_q;
        new_rot_d = new_rot_q;
        success_d = success_q;
        add_x     = ldir_q ? ccw_add_x : cw_add_x;
        add_y     = ldir_q ? ccw_add_y : cw_add_y;

        if (abort && state_q != S_IDLE) begin
            // Cancel wins over any checker answer; results stay untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rot_req) begin
                        lx_d    = cur_x;
                        ly_d    = cur_y;
                        lrot_d  = cur_rotation;
                        lidx_d  = idx;
                        ldir_d  = rot_dir;
                        step_d  = '0;
                        trot_d  = rot_dir ? (cur_rotation - 2'd1) : (cur_rotation + 2'd1);
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    // Wrap-around is intentional; the checker rejects off-board cells.
                    chk_x_d   = lx_q + sext_x(add_x);
                    chk_y_d   = ly_q + sext_y(add_y);
                    chk_rot_d = trot_q;
                    state_d   = S_CHECK;
                end
                S_CHECK: begin
                    if (chk_resp) begin
                        if (!chk_collide) begin
                            new_x_d   = chk_x_q;
                            new_y_d   = chk_y_q;
                            new_rot_d = chk_rot_q;
                            success_d = 1'b1;
                            state_d   = S_DONE;
                        end else if (step_q < LAST_STEP && lidx_q != TET_O) begin
                            step_d  = step_q + 3'd1;
                            state_d = S_CALC;
                        end else begin
                            new_x_d   = lx_q;
                            new_y_d   = ly_q;
                            new_rot_d = lrot_q;
                            success_d = 1'b0;
                            state_d   = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign kick_rotation = lrot_q;
    assign kick_step     = step_q;
    assign kick_idx      = lidx_q;
    assign chk_valid     = (state_q == S_CHECK);
    assign chk_x         = chk_x_q;
    assign chk_y         = chk_y_q;
    assign chk_rotation  = chk_rot_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign success       = success_q;
    assign new_x         = new_x_q;
    assign new_y         = new_y_q;
    assign new_rotation  = new_rot_q;

endmodule

// File: tb/tb_rotation_kick_sequencer.sv
// Bench for rotation_kick_sequencer: bench-owned kick tables, scripted and
// random checker answers, and a step-list reference model of each attempt.

module tb_rotation_kick_sequencer;
    import rotation_kick_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rot_req = 1'b0;
    logic       rot_dir = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] cur_x = '0;
    logic [5:0] cur_y = '0;
    logic [1:0] cur_rotation = '0;
    logic [2:0] idx = '0;
    logic [1:0] kick_rotation;
    logic [2:0] kick_step;
    logic [2:0] kick_idx;
    logic [2:0] cw_add_x, cw_add_y, ccw_add_x, ccw_add_y;
    logic       chk_valid;
    logic [4:0] chk_x;
    logic [5:0] chk_y;
    logic [1:0] chk_rotation;
    logic       chk_resp = 1'b0;
    logic       chk_collide = 1'b0;
    logic       busy, done, success;
    logic [4:0] new_x;
    logic [5:0] new_y;
    logic [1:0] new_rotation;

    logic [2:0] cw_x  [8][4][8];
    logic [2:0] cw_y  [8][4][8];
    logic [2:0] ccw_x [8][4][8];
    logic [2:0] ccw_y [8][4][8];

    int n_pass = 0;
    int n_total = 0;

    logic [4:0] last_x = '0;
    logic [5:0] last_y = '0;
    logic [1:0] last_rot = '0;
    logic       last_succ = 1'b0;

    always #5 clk = ~clk;

    assign cw_add_x  = cw_x[kick_idx][kick_rotation][kick_step];
    assign cw_add_y  = cw_y[kick_idx][kick_rotation][kick_step];
    assign ccw_add_x = ccw_x[kick_idx][kick_rotation][kick_step];
    assign ccw_add_y = ccw_y[kick_idx][kick_rotation][kick_step];

    rotation_kick_sequencer #(.X_WIDTH(5), .Y_WIDTH(6)) dut (
        .clk(clk), .reset_n(reset_n), .rot_req(rot_req), .rot_dir(rot_dir),
        .abort(abort), .cur_x(cur_x), .cur_y(cur_y), .cur_rotation(cur_rotation),
        .idx(idx), .kick_rotation(kick_rotation), .kick_step(kick_step),
        .kick_idx(kick_idx), .cw_add_x(cw_add_x), .cw_add_y(cw_add_y),
        .ccw_add_x(ccw_add_x), .ccw_add_y(ccw_add_y), .chk_valid(chk_valid),
        .chk_x(chk_x), .chk_y(chk_y), .chk_rotation(chk_rotation),
        .chk_resp(chk_resp), .chk_collide(chk_collide), .busy(busy), .done(done),
        .success(success), .new_x(new_x), .new_y(new_y), .new_rotation(new_rotation)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full rotation attempt. cmask[k]=1 means the checker reports a
    // collision for kick step k; dly is the checker wait per attempt.
    task automatic run_rot(input logic [2:0] p, input int x, input int y, input int r,
                           input bit d, input logic [4:0] cmask, input int dly,
                           input bit req_mid);
        int         max_att, free_k, n_att;
        logic [1:0] trot;
        logic [4:0] ex;
        logic [5:0] ey;
        logic [2:0] dx, dy;

        // Reference: try steps in order, first free step wins.
        trot    = d ? 2'(r + 3) : 2'(r + 1);
        max_att = (p == TET_O) ? 1 : 5;
        free_k  = -1;
        for (int k = 0; k < max_att; k++) begin
            if (!cmask[k]) begin
                free_k = k;
                break;
            end
        end
        n_att = (free_k >= 0) ? free_k + 1 : max_att;
        if (free_k >= 0) begin
            dx = d ? ccw_x[p][r][free_k] : cw_x[p][r][free_k];
            dy = d ? ccw_y[p][r][free_k] : cw_y[p][r][free_k];
            last_x    = 5'(x + int'($signed(dx)));
            last_y    = 6'(y + int'($signed(dy)));
            last_rot  = trot;
            last_succ = 1'b1;
        end else begin
            last_x    = 5'(x);
            last_y    = 6'(y);
            last_rot  = 2'(r);
            last_succ = 1'b0;
        end

        cur_x = 5'(x); cur_y = 6'(y); cur_rotation = 2'(r); idx = p; rot_dir = d;
        rot_req = 1'b1;
        tick();
        rot_req = 1'b0;
        chk("busy_after_accept", busy, 1);
        for (int k = 0; k < n_att; k++) begin
            chk("calc_kick_step", kick_step, k);
            chk("calc_kick_rot", kick_rotation, r);
            chk("calc_kick_idx", kick_idx, p);
            chk("calc_chk_valid", chk_valid, 0);
            chk("calc_done", done, 0);
            tick();
            dx = d ? ccw_x[p][r][k] : cw_x[p][r][k];
            dy = d ? ccw_y[p][r][k] : cw_y[p][r][k];
            ex = 5'(x + int'($signed(dx)));
            ey = 6'(y + int'($signed(dy)));
            for (int w = 0; w <= dly; w++) begin
                chk("check_valid", chk_valid, 1);
                chk("check_x", chk_x, ex);
                chk("check_y", chk_y, ey);
                chk("check_rot", chk_rotation, trot);
                chk("check_done", done, 0);
                rot_req = (req_mid && w == 0);
                if (w == dly) begin
                    chk_resp    = 1'b1;
                    chk_collide = cmask[k];
                end
                tick();
                chk_resp    = 1'b0;
                chk_collide = 1'b0;
                rot_req     = 1'b0;
            end
        end
        chk("done_pulse", done, 1);
        chk("done_valid_low", chk_valid, 0);
        chk("done_success", success, last_succ);
        chk("done_new_x", new_x, last_x);
        chk("done_new_y", new_y, last_y);
        chk("done_new_rot", new_rotation, last_rot);
        tick();
        chk("after_done_low", done, 0);
        chk("after_busy_low", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            for (int r = 0; r < 4; r++)
                for (int s = 0; s < 8; s++) begin
                    cw_x[i][r][s]  = 3'($urandom);
                    cw_y[i][r][s]  = 3'($urandom);
                    ccw_x[i][r][s] = 3'($urandom);
                    ccw_y[i][r][s] = 3'($urandom);
                end
        cw_x[TET_T][0][0] = 3'd0;  cw_y[TET_T][0][0] = 3'd0;
        ccw_x[TET_J][0][2] = 3'd1; ccw_y[TET_J][0][2] = 3'd1;
        ccw_x[TET_I][3][4] = 3'd1; ccw_y[TET_I][3][4] = 3'd2;

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", chk_valid, 0);
        chk("rst_chk_x", chk_x, 0);
        chk("rst_chk_y", chk_y, 0);
        chk("rst_chk_rot", chk_rotation, 0);
        chk("rst_kick_step", kick_step, 0);
        chk("rst_kick_rot", kick_rotation, 0);
        chk("rst_kick_idx", kick_idx, 0);
        chk("rst_success", success, 0);
        chk("rst_new_x", new_x, 0);
        chk("rst_new_y", new_y, 0);
        chk("rst_new_rot", new_rotation, 0);
        reset_n = 1'b1;
        tick();

        // Scripted scenarios from the block's intended use.
        run_rot(TET_T, 4, 10, 0, 1'b0, 5'b00000, 0, 1'b0);
        run_rot(TET_J, 4, 10, 0, 1'b1, 5'b00011, 0, 1'b0);
        run_rot(TET_I, 4, 10, 3, 1'b1, 5'b01111, 0, 1'b0);
        run_rot(TET_L, 0, 0, 1, 1'b1, 5'b11111, 0, 1'b0);
        run_rot(TET_O, 3, 7, 2, 1'b0, 5'b11111, 0, 1'b0);
        run_rot(TET_O, 3, 7, 3, 1'b0, 5'b00000, 0, 1'b0);
        run_rot(TET_O, 3, 7, 0, 1'b1, 5'b00000, 0, 1'b0);
        run_rot(TET_S, 30, 60, 2, 1'b0, 5'b00101, 3, 1'b1);

        // Abort in CHECK together with a free answer: abort wins.
        cur_x = 5'd9; cur_y = 6'd9; cur_rotation = 2'd2; idx = TET_Z; rot_dir = 1'b0;
        rot_req = 1'b1;
        tick();
        rot_req = 1'b0;
        tick();
        chk("abort_in_check", chk_valid, 1);
        abort = 1'b1; chk_resp = 1'b1; chk_collide = 1'b0;
        tick();
        abort = 1'b0; chk_resp = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_success_kept", success, last_succ);
        chk("abort_new_x_kept", new_x, last_x);
        chk("abort_new_y_kept", new_y, last_y);
        chk("abort_new_rot_kept", new_rotation, last_rot);
        tick();
        chk("abort_no_late_done", done, 0);

        // Asynchronous reset while in CALC.
        cur_x = 5'd2; cur_y = 6'd3; cur_rotation = 2'd1; idx = TET_T; rot_dir = 1'b1;
        rot_req = 1'b1;
        tick();
        rot_req = 1'b0;
        chk("pre_reset_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_new_x", new_x, 0);
        chk("areset_success", success, 0);
        chk("areset_kick_rot", kick_rotation, 0);
        tick();
        reset_n = 1'b1;
        tick();
        run_rot(TET_T, 2, 3, 1, 1'b1, 5'b00001, 1, 1'b0);

        // Random transactions.
        for (int n = 0; n < 30; n++) begin
            run_rot(3'($urandom_range(0, 6)), $urandom_range(0, 31), $urandom_range(0, 63),
                    $urandom_range(0, 3), 1'($urandom), 5'($urandom),
                    $urandom_range(0, 2), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
